// File: rtl/mips_pkg.sv
// +------------------------------------------------------------------+
// | mips_pkg : shared encodings for the MIPS execute stage.  Rev 1.0 |
// +------------------------------------------------------------------+
`default_nettype none

package mips_pkg;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_AND   = 4'd2,
    ALU_OR    = 4'd3,
    ALU_XOR   = 4'd4,
    ALU_NOR   = 4'd5,
    ALU_SLT   = 4'd6,
    ALU_SLL   = 4'd7,
    ALU_SRL   = 4'd8,
    ALU_SRA   = 4'd9,
    ALU_LUI   = 4'd10,
    ALU_MFHI  = 4'd11,
    ALU_MFLO  = 4'd12,
    ALU_MULT  = 4'd13,
    ALU_MULTU = 4'd14,
    ALU_NOP   = 4'd15
  } alu_op_e;

  localparam logic [1:0] FWD_RF  = 2'd0;
  localparam logic [1:0] FWD_WB  = 2'd1;
  localparam logic [1:0] FWD_MEM = 2'd2;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mul_state_e;

  // Instructions that must wait for an in-flight multiply to finish.
  function automatic logic uses_hilo(input alu_op_e op);
    return (op == ALU_MFHI) || (op == ALU_MFLO) || (op == ALU_MULT) || (op == ALU_MULTU);
  endfunction

endpackage

`default_nettype wire

// File: rtl/ex_stage_if.sv
// +------------------------------------------------------------------+
// | ex_stage_if : ID/EX, forwarding and EX/MEM signal bundle.         |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
`default_nettype none

interface ex_stage_if #(
  parameter int XLEN = 32
);
  import mips_pkg::*;

  logic            id_valid;
  alu_op_e         id_aluOp;
  logic [XLEN-1:0] id_rs_data;
  logic [XLEN-1:0] id_rt_data;
  logic [XLEN-1:0] id_imm;
  logic            id_aluSrc;
  logic [4:0]      id_shamt;
  logic [4:0]      id_Rd;
  logic            id_regWrite;
  logic            id_memRead;
  logic            id_memWrite;
  logic            id_memToReg;
  logic [1:0]      frwrdA;
  logic [1:0]      frwrdB;
  logic [XLEN-1:0] wb_data;
  logic            ex_flush;
  logic            ex_stall;
  logic [XLEN-1:0] mem_aluRes;
  logic [XLEN-1:0] mem_storeData;
  logic [4:0]      mem_Rd;
  logic            mem_regWrite;
  logic            mem_memRead;
  logic            mem_memWrite;
  logic            mem_memToReg;
  logic            mem_zero;

  modport master (
    output id_valid, id_aluOp, id_rs_data, id_rt_data, id_imm, id_aluSrc,
           id_shamt, id_Rd, id_regWrite, id_memRead, id_memWrite, id_memToReg,
           frwrdA, frwrdB, wb_data, ex_flush,
    input  ex_stall, mem_aluRes, mem_storeData, mem_Rd, mem_regWrite,
           mem_memRead, mem_memWrite, mem_memToReg, mem_zero
  );

  modport slave (
    input  id_valid, id_aluOp, id_rs_data, id_rt_data, id_imm, id_aluSrc,
           id_shamt, id_Rd, id_regWrite, id_memRead, id_memWrite, id_memToReg,
           frwrdA, frwrdB, wb_data, ex_flush,
    output ex_stall, mem_aluRes, mem_storeData, mem_Rd, mem_regWrite,
           mem_memRead, mem_memWrite, mem_memToReg, mem_zero
  );

endinterface

`default_nettype wire

// File: rtl/ex_stage_mult_unit.sv
// +------------------------------------------------------------------+
// | mult_unit : iterative shift-add multiplier owning HI/LO.  Rev 1.0 |
// +------------------------------------------------------------------+
`default_nettype none

module mult_unit
  import mips_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int MUL_CYCLES = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_i,
  input  logic            signed_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic            busy_o,
  output logic [XLEN-1:0] hi_o,
  output logic [XLEN-1:0] lo_o
);

  localparam int CNT_W = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;

  mul_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2*XLEN-1:0] mcand_q, mcand_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [2*XLEN-1:0] acc_step;
  logic [XLEN-1:0]   mplier_q, mplier_d;
  logic [XLEN-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic [XLEN-1:0]   mag_a, mag_b;
  logic              neg_q, neg_d;

  // Work on magnitudes; the sign is reapplied to the full product at write-back.
  assign mag_a    = (signed_i && a_i[XLEN-1]) ? -a_i : a_i;
  assign mag_b    = (signed_i && b_i[XLEN-1]) ? -b_i : b_i;
  assign acc_step = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    neg_d    = neg_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d  = BUSY;
          cnt_d    = CNT_W'(MUL_CYCLES - 1);
          mcand_d  = {{XLEN{1'b0}}, mag_a};
          mplier_d = mag_b;
          acc_d    = '0;
          neg_d    = signed_i && (a_i[XLEN-1] ^ b_i[XLEN-1]);
        end
      end
      BUSY: begin
        acc_d    = acc_step;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q - CNT_W'(1);
        if (cnt_q == '0) begin
          state_d      = IDLE;
          {hi_d, lo_d} = neg_q ? -acc_step : acc_step;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      neg_q    <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      neg_q    <= neg_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign busy_o = (state_q == BUSY);
  assign hi_o   = hi_q;
  assign lo_o   = lo_q;

endmodule

`default_nettype wire

// File: rtl/ex_stage.sv
// +------------------------------------------------------------------+
// | ex_stage : MIPS EX stage - forwarding muxes, ALU, HI/LO interlock |
// | and EX/MEM pipeline register.  Rev 1.0                            |
// +------------------------------------------------------------------+
`default_nettype none

module ex_stage
  import mips_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int MUL_CYCLES = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  ex_stage_if.slave  ex_if
);

  logic [XLEN-1:0] fwd_a_raw, fwd_b_raw;
  logic [XLEN-1:0] op_a, fwd_b, op_b, alu_res;
  logic [XLEN-1:0] hi, lo;
  logic            mul_busy, is_mult, stall, issue, mul_start;

  logic            hold_valid_q, hold_valid_d;
  logic [XLEN-1:0] hold_a_q, hold_a_d, hold_b_q, hold_b_d;

  logic [XLEN-1:0] mem_aluRes_q, mem_aluRes_d;
  logic [XLEN-1:0] mem_storeData_q, mem_storeData_d;
  logic [4:0]      mem_Rd_q, mem_Rd_d;
  logic            mem_regWrite_q, mem_regWrite_d;
  logic            mem_memRead_q, mem_memRead_d;
  logic            mem_memWrite_q, mem_memWrite_d;
  logic            mem_memToReg_q, mem_memToReg_d;
  logic            mem_zero_q, mem_zero_d;

  function automatic logic [XLEN-1:0] fwd_sel(input logic [1:0] sel, input logic [XLEN-1:0] rf,
                                              input logic [XLEN-1:0] wb, input logic [XLEN-1:0] mem);
    case (sel)
      FWD_WB:  fwd_sel = wb;
      FWD_MEM: fwd_sel = mem;
      default: fwd_sel = rf;
    endcase
  endfunction

  assign fwd_a_raw = fwd_sel(ex_if.frwrdA, ex_if.id_rs_data, ex_if.wb_data, mem_aluRes_q);
  assign fwd_b_raw = fwd_sel(ex_if.frwrdB, ex_if.id_rt_data, ex_if.wb_data, mem_aluRes_q);

  // Once stalled, the forwarding sources may drain; the held copies stay authoritative.
  assign op_a  = hold_valid_q ? hold_a_q : fwd_a_raw;
  assign fwd_b = hold_valid_q ? hold_b_q : fwd_b_raw;
  assign op_b  = ex_if.id_aluSrc ? ex_if.id_imm : fwd_b;

  assign is_mult   = (ex_if.id_aluOp == ALU_MULT) || (ex_if.id_aluOp == ALU_MULTU);
  assign stall     = mul_busy && ex_if.id_valid && uses_hilo(ex_if.id_aluOp);
  assign issue     = ex_if.id_valid && !stall && !ex_if.ex_flush;
  assign mul_start = issue && is_mult;

  assign hold_valid_d = stall && !ex_if.ex_flush;
  assign hold_a_d     = (stall && !hold_valid_q) ? fwd_a_raw : hold_a_q;
  assign hold_b_d     = (stall && !hold_valid_q) ? fwd_b_raw : hold_b_q;

  mult_unit #(
    .XLEN       (XLEN),
    .MUL_CYCLES (MUL_CYCLES)
  ) u_mult (
    .clk      (clk),
    .rst_n    (rst_n),
    .start_i  (mul_start),
    .signed_i (ex_if.id_aluOp == ALU_MULT),
    .a_i      (op_a),
    .b_i      (fwd_b),
    .busy_o   (mul_busy),
    .hi_o     (hi),
    .lo_o     (lo)
  );

  always_comb begin
    alu_res = '0;
    case (ex_if.id_aluOp)
      ALU_ADD:  alu_res = op_a + op_b;
      ALU_SUB:  alu_res = op_a - op_b;
      ALU_AND:  alu_res = op_a & op_b;
      ALU_OR:   alu_res = op_a | op_b;
      ALU_XOR:  alu_res = op_a ^ op_b;
      ALU_NOR:  alu_res = ~(op_a | op_b);
      ALU_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      ALU_SLL:  alu_res = op_b << ex_if.id_shamt;
      ALU_SRL:  alu_res = op_b >> ex_if.id_shamt;
      ALU_SRA:  alu_res = $signed(op_b) >>> ex_if.id_shamt;
      ALU_LUI:  alu_res = op_b << 16;
      ALU_MFHI: alu_res = hi;
      ALU_MFLO: alu_res = lo;
      default:  alu_res = '0;
    endcase
  end

  // Stalls, flushes and invalid slots all leave a bubble in EX/MEM.
  always_comb begin
    mem_aluRes_d    = '0;
    mem_storeData_d = '0;
    mem_Rd_d        = '0;
    mem_regWrite_d  = 1'b0;
    mem_memRead_d   = 1'b0;
    mem_memWrite_d  = 1'b0;
    mem_memToReg_d  = 1'b0;
    mem_zero_d      = 1'b0;
    if (issue) begin
      mem_aluRes_d    = alu_res;
      mem_storeData_d = fwd_b;
      mem_Rd_d        = ex_if.id_Rd;
      mem_regWrite_d  = ex_if.id_regWrite && !is_mult;
      mem_memRead_d   = ex_if.id_memRead;
      mem_memWrite_d  = ex_if.id_memWrite;
      mem_memToReg_d  = ex_if.id_memToReg;
      mem_zero_d      = (alu_res == '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_valid_q    <= 1'b0;
      hold_a_q        <= '0;
      hold_b_q        <= '0;
      mem_aluRes_q    <= '0;
      mem_storeData_q <= '0;
      mem_Rd_q        <= '0;
      mem_regWrite_q  <= 1'b0;
      mem_memRead_q   <= 1'b0;
      mem_memWrite_q  <= 1'b0;
      mem_memToReg_q  <= 1'b0;
      mem_zero_q      <= 1'b0;
    end else begin
      hold_valid_q    <= hold_valid_d;
      hold_a_q        <= hold_a_d;
      hold_b_q        <= hold_b_d;
      mem_aluRes_q    <= mem_aluRes_d;
      mem_storeData_q <= mem_storeData_d;
      mem_Rd_q        <= mem_Rd_d;
      mem_regWrite_q  <= mem_regWrite_d;
      mem_memRead_q   <= mem_memRead_d;
      mem_memWrite_q  <= mem_memWrite_d;
      mem_memToReg_q  <= mem_memToReg_d;
      mem_zero_q      <= mem_zero_d;
    end
  end

  assign ex_if.ex_stall      = stall;
  assign ex_if.mem_aluRes    = mem_aluRes_q;
  assign ex_if.mem_storeData = mem_storeData_q;
  assign ex_if.mem_Rd        = mem_Rd_q;
  assign ex_if.mem_regWrite  = mem_regWrite_q;
  assign ex_if.mem_memRead   = mem_memRead_q;
  assign ex_if.mem_memWrite  = mem_memWrite_q;
  assign ex_if.mem_memToReg  = mem_memToReg_q;
  assign ex_if.mem_zero      = mem_zero_q;

endmodule

`default_nettype wire

// File: doc/ex_stage.md
# ex_stage

Execute stage of the 5-stage MIPS pipeline, directly downstream of the forwarding unit. It consumes the ID/EX operands and the `frwrdA`/`frwrdB` selects, applies the forwarding muxes and the ALU, and owns the EX/MEM pipeline register. It also holds the HI/LO registers and a multi-cycle multiplier, and interlocks HI/LO-dependent instructions while a multiply is in flight.

## Interface
- `XLEN`, default 32: datapath width.
- `MUL_CYCLES`, default 32: busy cycles per multiply.

Ports:
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `id_valid` in 1: ID/EX holds a real instruction.
- `id_aluOp` in 4: ALU operation code (see Operation).
- `id_rs_data`, `id_rt_data` in XLEN: register-file read data.
- `id_imm` in XLEN: sign/zero-extended immediate.
- `id_aluSrc` in 1: 1 selects `id_imm` as operand B.
- `id_shamt` in 5: shift amount.
- `id_Rd` in 5: destination register, already resolved.
- `id_regWrite`, `id_memRead`, `id_memWrite`, `id_memToReg` in 1: control bits.
- `frwrdA`, `frwrdB` in 2: forwarding selects. 0 = register file, 1 = `wb_data`, 2 = `mem_aluRes`. 3 is treated as 0.
- `wb_data` in XLEN: MEM/WB writeback value.
- `ex_flush` in 1: squash the instruction currently in EX.
- `ex_stall` out 1: hold PC, IF/ID and ID/EX this cycle.
- `mem_aluRes` out XLEN: EX/MEM ALU result.
- `mem_storeData` out XLEN: forwarded operand B before the `aluSrc` mux.
- `mem_Rd` out 5, `mem_regWrite`/`mem_memRead`/`mem_memWrite`/`mem_memToReg` out 1, `mem_zero` out 1: EX/MEM register contents.

## Operation
- **Operands.**
  - `opA` = fwd(`frwrdA`, `id_rs_data`).
  - `fwdB` = fwd(`frwrdB`, `id_rt_data`).
  - `opB` = `id_aluSrc` ? `id_imm` : `fwdB`.
  - When the hold register is valid, `opA` and `fwdB` come from the held copies instead.
- **ALU ops.** All arithmetic wraps modulo 2^XLEN; there is no overflow trap.
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR.
  - 6 SLT: signed compare, result 1 or 0.
  - 7 SLL, 8 SRL, 9 SRA: shift `opB` by `id_shamt`.
  - 10 LUI: `opB`<<16.
  - 11 MFHI, 12 MFLO.
  - 13 MULT (signed), 14 MULTU.
  - 15: result 0.
  - `mem_zero` = (result == 0).
- **Multiplier FSM** (states IDLE, BUSY):
  - IDLE→BUSY: a valid, unflushed MULT/MULTU is in EX and the unit is IDLE. Capture `opA`/`fwdB` and load the counter with MUL_CYCLES−1.
  - The MULT itself writes nothing to the register file. It enters EX/MEM with `regWrite`=0.
  - BUSY: one shift-add step per cycle on the operand magnitudes. Signed sign-fix (negate the 64-bit product) is applied at the write.
  - BUSY→IDLE: when the counter reaches 0, {HI,LO} is written on that edge.
- **Interlock.**
  - `ex_stall` = BUSY && `id_valid` && aluOp ∈ {MFHI, MFLO, MULT, MULTU}. It is combinational.
  - Other instructions flow freely while BUSY.
- **Stall behaviour.**
  - While `ex_stall` is high, a bubble loads into EX/MEM: all control bits 0, `mem_Rd`=0.
  - On the first stall cycle, `opA`/`fwdB` are latched into the hold register and hold-valid is set. This keeps the operands valid after forwarding sources drain.
  - Hold-valid clears when the stalled instruction executes, or on `ex_flush`.
- **Flush.**
  - `ex_flush` loads a bubble and suppresses the IDLE→BUSY transition.
  - It does not abort a multiply already BUSY.
  - If flush and stall occur together, the flush wins: a bubble, hold cleared, and `ex_stall` still reported.
- **`id_valid` low:** a bubble is loaded.

## Timing
- **Reset:** all EX/MEM outputs 0, HI=LO=0, state IDLE, hold-valid 0. `ex_stall` is 0.
- **ALU latency:** one cycle. The result appears on `mem_*` the edge after the instruction is in EX.
- **MULT latency:** MULT is in EX at cycle T; `ex_stall` can be high during T+1..T+MUL_CYCLES. A dependent MFHI/MFLO executes at T+MUL_CYCLES+1 and sees the new HI/LO.
- **Back-to-back MULT:** the second MULT stalls, then issues in the cycle the FSM returns to IDLE.
- **Mid-operation reset:** returns to IDLE, HI/LO cleared, the partial product is discarded.

## Structure
- Shared package `mips_pkg`:
  - `alu_op_e` enum (4-bit codes above).
  - `FWD_RF`=0, `FWD_WB`=1, `FWD_MEM`=2.
  - `mul_state_e` {IDLE, BUSY}.
- Sub-module `mult_unit`: FSM, counter, shift-add datapath and HI/LO. Interface: start, signed flag, operands, busy, hi, lo.
- `ex_stage` keeps the muxes, ALU, hold register and EX/MEM register.

## Test plan
- ADD with `id_rs_data`=5, `id_rt_data`=7, frwrdA=2 while `mem_aluRes`=100 → next edge `mem_aluRes`=107, `mem_zero`=0.
- SLT −1 vs 1 → 1. SRA 0x80000000 by 4 → 0xF8000000. SUB 3−3 → `mem_zero`=1.
- MULT −3×7, then MFLO in the next cycle → `ex_stall` high for 32 cycles, EX/MEM shows bubbles, then `mem_aluRes`=0xFFFFFFEB. MFHI → 0xFFFFFFFF.
- MULTU 0xFFFFFFFF×2, followed by independent ADDs → the ADDs complete without stall, and after completion HI=1, LO=0xFFFFFFFE.
- Stalled MULT whose rs was forwarded (frwrdA=1, `wb_data`=9) on the first stall cycle, with `wb_data` changed afterwards → the product uses 9.
- `ex_flush` on a MULT in EX → no BUSY and HI/LO unchanged. Assert `rst_n` low mid-multiply → outputs 0 and IDLE immediately.
